// File: rtl/fp_pkg.sv
// fp_pkg: constants and FSM state encoding shared by the sequential
// single-precision multiplier and its operand classifier.
package fp_pkg;
    localparam int BIAS = 127;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    typedef enum logic [2:0] {IDLE, MULT, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/ks_vandana_fp_classify.sv
// ks_vandana_fp_classify: flags an unsigned exponent/fraction field as
// zero, denormal, infinity or NaN.
module ks_vandana_fp_classify
    import fp_pkg::*;
#(
    parameter int MAN_W = 23,
    parameter int EXP_W = 8
) (
    input  logic [EXP_W+MAN_W-1:0] i_x,
    output logic                   o_zero,
    output logic                   o_inf,
    output logic                   o_nan,
    output logic                   o_denorm
);
    logic w_exp_max, w_exp_min, w_frac_nz;

    assign w_exp_max = &i_x[EXP_W+MAN_W-1:MAN_W];
    assign w_exp_min = ~|i_x[EXP_W+MAN_W-1:MAN_W];
    assign w_frac_nz = |i_x[MAN_W-1:0];
    assign o_zero    = w_exp_min & ~w_frac_nz;
    assign o_denorm  = w_exp_min & w_frac_nz;
    assign o_inf     = w_exp_max & ~w_frac_nz;
    assign o_nan     = w_exp_max & w_frac_nz;
endmodule

// File: rtl/ks_vandana_fp_mul_seq.sv
// ks_vandana_fp_mul_seq: single-precision multiplier using a one-bit-per-cycle
// shift-add mantissa product; every operation takes the same 26 cycles.
module ks_vandana_fp_mul_seq
    import fp_pkg::*;
#(
    parameter int MAN_W = 23,
    parameter int EXP_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   c
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MW;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(MW + 1);
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    state_t          r_state, w_next;
    logic [PW-1:0]   r_mcand, r_acc;
    logic [MW-1:0]   r_mplier;
    logic [CW-1:0]   r_cnt;
    logic            r_sign, r_special;
    logic [EW-1:0]   r_exp;
    logic [W-1:0]    r_spec_val, r_c;

    logic            w_a_zero, w_a_inf, w_a_nan, w_a_den;
    logic            w_b_zero, w_b_inf, w_b_nan, w_b_den;
    logic            w_az, w_bz, w_sign, w_nan, w_inf, w_special;
    logic [W-1:0]    w_spec_val, w_result;
    logic [EW-1:0]   w_exp_in, w_exp_r;
    logic [MW-1:0]   w_mant;
    logic [MW:0]     w_rnd;
    logic [MAN_W-1:0] w_frac;
    logic            w_guard, w_rbit, w_sticky, w_up, w_ovf, w_unf;

    ks_vandana_fp_classify #(.MAN_W(MAN_W), .EXP_W(EXP_W)) u_cls_a (
        .i_x(a[W-2:0]), .o_zero(w_a_zero), .o_inf(w_a_inf), .o_nan(w_a_nan), .o_denorm(w_a_den)
    );
    ks_vandana_fp_classify #(.MAN_W(MAN_W), .EXP_W(EXP_W)) u_cls_b (
        .i_x(b[W-2:0]), .o_zero(w_b_zero), .o_inf(w_b_inf), .o_nan(w_b_nan), .o_denorm(w_b_den)
    );

    // Denormals collapse to zero before the special-case decision.
    assign w_az       = w_a_zero | w_a_den;
    assign w_bz       = w_b_zero | w_b_den;
    assign w_sign     = a[W-1] ^ b[W-1];
    assign w_nan      = w_a_nan | w_b_nan | (w_a_inf & w_bz) | (w_b_inf & w_az);
    assign w_inf      = w_a_inf | w_b_inf;
    assign w_special  = w_nan | w_inf | w_az | w_bz;
    assign w_spec_val = w_nan ? QNAN[W-1:0] : w_inf ? {w_sign, POS_INF[W-2:0]} : {w_sign, (W-1)'(0)};
    assign w_exp_in   = EW'(a[W-2:MAN_W]) + EW'(b[W-2:MAN_W]) - EW'(BIAS);

    // After NORM the leading one always sits at PW-2.
    assign w_mant   = r_acc[PW-2 -: MW];
    assign w_guard  = r_acc[PW-2-MW];
    assign w_rbit   = r_acc[PW-3-MW];
    assign w_sticky = |r_acc[PW-4-MW:0];
    assign w_up     = w_guard & (w_rbit | w_sticky | w_mant[0]);
    assign w_rnd    = {1'b0, w_mant} + (MW+1)'(w_up);
    assign w_frac   = w_rnd[MW] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    assign w_exp_r  = r_exp + EW'(w_rnd[MW]);
    assign w_ovf    = $signed(w_exp_r) >= $signed(EXP_MAX);
    assign w_unf    = w_exp_r[EW-1] | (w_exp_r == '0);
    assign w_result = r_special ? r_spec_val :
                      w_ovf     ? {r_sign, POS_INF[W-2:0]} :
                      w_unf     ? {r_sign, (W-1)'(0)} :
                                  {r_sign, w_exp_r[EXP_W-1:0], w_frac};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? MULT : IDLE;
            MULT:    w_next = (r_cnt == CW'(MW - 1)) ? NORM : MULT;
            NORM:    w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_c        <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_mcand    <= PW'({1'b1, a[MAN_W-1:0]});
                    r_mplier   <= {1'b1, b[MAN_W-1:0]};
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_sign     <= w_sign;
                    r_exp      <= w_exp_in;
                    r_special  <= w_special;
                    r_spec_val <= w_spec_val;
                end
                MULT: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= (r_cnt == CW'(MW)) ? r_cnt : r_cnt + CW'(1);
                end
                // The bit shifted out folds into the sticky region.
                NORM: if (r_acc[PW-1]) begin
                    r_acc <= {1'b0, r_acc[PW-1:2], r_acc[1] | r_acc[0]};
                    r_exp <= r_exp + EW'(1);
                end
                ROUND:   r_c <= w_result;
                default: ;
            endcase
        end
    end

    assign busy = (r_state == MULT) | (r_state == NORM) | (r_state == ROUND);
    assign done = r_state == DONE;
    assign c    = r_c;
endmodule

// File: tb/tb_ks_vandana_fp_mul_seq.sv
// tb_ks_vandana_fp_mul_seq: random and directed operands against an arithmetic
// reference model, with a scoreboard queue drained by an output monitor.
module tb_ks_vandana_fp_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] c;

    typedef struct {
        logic [31:0] c;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   free_at = 0;
    int   errors = 0;
    int   checks = 0;
    int   n_done = 0;

    ks_vandana_fp_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .start(start),
        .busy(busy), .done(done), .c(c)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        int     ea = int'(x[30:23]);
        int     eb = int'(y[30:23]);
        logic   s = x[31] ^ y[31];
        logic   za = (ea == 0), zb = (eb == 0);
        logic   ia = (ea == 255) && (x[22:0] == 0), ib = (eb == 255) && (y[22:0] == 0);
        logic   na = (ea == 255) && (x[22:0] != 0), nb = (eb == 255) && (y[22:0] != 0);
        longint p, q, rem, half;
        int     e, sh;
        if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC0_0000;
        if (ia || ib) return {s, 31'h7F80_0000};
        if (za || zb) return {s, 31'h0};
        p = (64'h80_0000 | longint'(x[22:0])) * (64'h80_0000 | longint'(y[22:0]));
        e = ea + eb - 127;
        sh = 23;
        if (p >= 64'h8000_0000_0000) begin
            sh = 24;
            e++;
        end
        q = p >> sh;
        rem = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == 64'h100_0000) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {s, 31'h7F80_0000};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), 23'(q)};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r = $urandom;
        int k = $urandom_range(0, 9);
        if (k == 0) r[30:23] = 8'h00;
        else if (k == 1) begin
            r[30:23] = 8'hFF;
            if ($urandom_range(0, 1) == 1) r[22:0] = '0;
        end else if (k == 2) r[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFE : 8'h01;
        else if (k == 3) begin
            r[30:23] = 8'($urandom_range(100, 150));
            r[15:0] = '0;
        end else if (k < 9) r[30:23] = 8'($urandom_range(64, 190));
        return r;
    endfunction

    // Acceptance model: an accepted start is answered 26 edges later and the
    // next one can be taken two edges after that.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) free_at = 0;
        else if (start && cyc >= free_at) begin
            sb.push_back('{ref_mul(a, b), cyc + 26});
            free_at = cyc + 28;
        end
    end

    always @(negedge clk) begin
        logic bexp;
        if (!rst_n) sb.delete();
        else begin
            bexp = 1'b0;
            if (sb.size() > 0) bexp = cyc < sb[0].due;
            check("busy", {31'b0, busy}, {31'b0, bexp});
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done=1 with c=%h, expected no done at cycle %0d", c, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("c", c, mon_e.c);
                    check("latency", cyc, mon_e.due);
                end
            end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_done: got done=0, expected done with c=%h at cycle %0d", sb[0].c, cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic wait_idle(input int bound);
        int i = 0;
        while (sb.size() > 0 && i < bound) begin
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            #1;
            i++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic op(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        #1;
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_idle(40);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_c", c, 32'h0);
        rst_n = 1'b1;
        op(32'h4020_0000, 32'h4080_0000);
        op(32'hC040_0000, 32'h3F00_0000);
        op(32'h7F80_0000, 32'h0000_0000);
        op(32'h7F00_0000, 32'h7F00_0000);
        op(32'h0080_0000, 32'h0080_0000);
        op(32'h7FC1_2345, 32'h3F80_0000);
        op(32'hFF80_0000, 32'h4000_0000);

        // Start held high across whole operations, including the DONE cycle.
        @(negedge clk);
        #1;
        a = 32'h3FC0_0000;
        b = 32'h4000_0000;
        start = 1'b1;
        d0 = n_done;
        repeat (40) begin
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        wait_idle(80);
        check("held_start_dones", 32'(n_done - d0), 32'd2);

        // Asynchronous reset ten cycles into MULT.
        @(negedge clk);
        #1;
        a = 32'h4040_0000;
        b = 32'h4040_0000;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_c", c, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        d0 = n_done;
        repeat (30) @(negedge clk);
        #1;
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        op(32'h4040_0000, 32'h4040_0000);

        for (int i = 0; i < 150; i++) op(rnd_fp(), rnd_fp());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end
endmodule
